// File: rtl/hazard_stall_controller_if.sv
// Pipeline-to-hazard-controller bundle: decode/execute status in, stall/bubble/flush controls out.
interface hazard_stall_controller_if #(
    parameter int unsigned REG_ADDR_W = 5
);
    logic                  decValid;
    logic [REG_ADDR_W-1:0] decRs1;
    logic [REG_ADDR_W-1:0] decRs2;
    logic                  decUseRs1;
    logic                  decUseRs2;
    logic                  exValid;
    logic                  exIsLoad;
    logic [REG_ADDR_W-1:0] exRd;
    logic                  exBranchTaken;
    logic                  memBusy;

    logic                  fetchStall;
    logic                  decodeStall;
    logic                  exBubble;
    logic                  flushFetch;
    logic                  flushDecode;
    logic                  ctrlState;
    logic [31:0]           perfStallCycles;
    logic [15:0]           perfFlushCount;

    modport master (
        output decValid, decRs1, decRs2, decUseRs1, decUseRs2,
               exValid, exIsLoad, exRd, exBranchTaken, memBusy,
        input  fetchStall, decodeStall, exBubble, flushFetch, flushDecode,
               ctrlState, perfStallCycles, perfFlushCount
    );

    modport slave (
        input  decValid, decRs1, decRs2, decUseRs1, decUseRs2,
               exValid, exIsLoad, exRd, exBranchTaken, memBusy,
        output fetchStall, decodeStall, exBubble, flushFetch, flushDecode,
               ctrlState, perfStallCycles, perfFlushCount
    );
endinterface

// File: rtl/hazard_stall_controller.sv
// In-order pipeline hazard controller: load-use stall, memory-wait freeze, multi-cycle branch flush.
// Optional perf counters are built when HAZARD_PERF_COUNTER_EN is defined.
module hazard_stall_controller #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned REG_ADDR_W   = 5
) (
    input logic                    clk,
    input logic                    rst,
    hazard_stall_controller_if.slave bus
);
    localparam int unsigned CNT_W        = 4;
    localparam int unsigned STALL_CNT_W  = 32;
    localparam int unsigned FLUSH_CNT_W  = 16;
    localparam logic [CNT_W-1:0] FLUSH_RELOAD = CNT_W'(FLUSH_CYCLES - 1);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      flushCnt;

    logic [REG_ADDR_W-1:0] decRs1;
    logic [REG_ADDR_W-1:0] decRs2;
    logic [REG_ADDR_W-1:0] exRd;
    logic                  loadUse;
    logic                  startFlush;
    logic                  fetchStallC;
    logic                  decodeStallC;
    logic                  exBubbleC;
    logic                  flushC;

    assign decRs1 = bus.decRs1;
    assign decRs2 = bus.decRs2;
    assign exRd   = bus.exRd;

    // x0 is hardwired zero, so a load targeting it never creates a dependency
    assign loadUse = bus.decValid & bus.exValid & bus.exIsLoad & (exRd != '0) &
                     ((bus.decUseRs1 & (decRs1 == exRd)) |
                      (bus.decUseRs2 & (decRs2 == exRd)));

    // Same-cycle controls; everything forced low while reset is held
    always_comb begin
        fetchStallC  = 1'b0;
        decodeStallC = 1'b0;
        exBubbleC    = 1'b0;
        flushC       = 1'b0;
        startFlush   = 1'b0;
        if (!rst) begin
            if (bus.memBusy) begin
                fetchStallC  = 1'b1;
                decodeStallC = 1'b1;
            end else if (state == RUN && bus.exBranchTaken) begin
                startFlush = 1'b1;
            end else if (state == RUN && loadUse) begin
                fetchStallC  = 1'b1;
                decodeStallC = 1'b1;
                exBubbleC    = 1'b1;
            end
            if (state == FLUSH || startFlush) begin
                flushC    = 1'b1;
                exBubbleC = !bus.memBusy;
            end
        end
    end

    assign bus.fetchStall  = fetchStallC;
    assign bus.decodeStall = decodeStallC;
    assign bus.exBubble    = exBubbleC;
    assign bus.flushFetch  = flushC;
    assign bus.flushDecode = flushC;
    assign bus.ctrlState   = (state == FLUSH);

    // Flush sequencer; a memory wait freezes both state and count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            flushCnt <= '0;
        end else if (!bus.memBusy) begin
            case (state)
                RUN: begin
                    if (startFlush && FLUSH_CYCLES > 1) begin
                        state    <= FLUSH;
                        flushCnt <= FLUSH_RELOAD;
                    end
                end
                FLUSH: begin
                    if (flushCnt <= CNT_W'(1)) begin
                        state    <= RUN;
                        flushCnt <= '0;
                    end else begin
                        flushCnt <= flushCnt - CNT_W'(1);
                    end
                end
                default: begin
                    state    <= RUN;
                    flushCnt <= '0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_COUNTER_EN
    logic [STALL_CNT_W-1:0] perfStallCycles;
    logic [FLUSH_CNT_W-1:0] perfFlushCount;

    // Free-running, wrapping event counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perfStallCycles <= '0;
            perfFlushCount  <= '0;
        end else begin
            if (decodeStallC) perfStallCycles <= perfStallCycles + STALL_CNT_W'(1);
            if (startFlush)   perfFlushCount  <= perfFlushCount + FLUSH_CNT_W'(1);
        end
    end

    assign bus.perfStallCycles = perfStallCycles;
    assign bus.perfFlushCount  = perfFlushCount;
`else
    assign bus.perfStallCycles = '0;
    assign bus.perfFlushCount  = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller: vector table for RUN-state decode, hand sequences for flush/reset.
module tb_hazard_stall_controller;
    localparam int unsigned RW = 5;

`ifdef HAZARD_PERF_COUNTER_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_stall_controller_if #(.REG_ADDR_W(RW)) bus ();

    hazard_stall_controller #(.FLUSH_CYCLES(3), .REG_ADDR_W(RW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string           name;
        logic            decValid;
        logic [RW-1:0]   decRs1;
        logic [RW-1:0]   decRs2;
        logic            useRs1;
        logic            useRs2;
        logic            exValid;
        logic            exIsLoad;
        logic [RW-1:0]   exRd;
        logic            branch;
        logic            memBusy;
        logic [5:0]      expOut; // {fetchStall, decodeStall, exBubble, flushFetch, flushDecode, ctrlState}
    } vec_t;

    int nCompared   = 0;
    int nMismatched = 0;

    function automatic logic [5:0] outs();
        return {bus.fetchStall, bus.decodeStall, bus.exBubble,
                bus.flushFetch, bus.flushDecode, bus.ctrlState};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.decValid = 1'b0; bus.decRs1 = '0; bus.decRs2 = '0;
        bus.decUseRs1 = 1'b0; bus.decUseRs2 = 1'b0;
        bus.exValid = 1'b0; bus.exIsLoad = 1'b0; bus.exRd = '0;
        bus.exBranchTaken = 1'b0; bus.memBusy = 1'b0;
    endtask

    task automatic applyVec(input vec_t v);
        bus.decValid = v.decValid; bus.decRs1 = v.decRs1; bus.decRs2 = v.decRs2;
        bus.decUseRs1 = v.useRs1; bus.decUseRs2 = v.useRs2;
        bus.exValid = v.exValid; bus.exIsLoad = v.exIsLoad; bus.exRd = v.exRd;
        bus.exBranchTaken = v.branch; bus.memBusy = v.memBusy;
    endtask

    // Sample the combinational controls away from the rising edge
    task automatic step(input string name, input logic [5:0] exp);
        #1;
        check(name, 32'(outs()), 32'(exp));
    endtask

    task automatic setLoadUse();
        idle();
        bus.decValid = 1'b1; bus.decRs1 = 5'd5; bus.decUseRs1 = 1'b1;
        bus.exValid = 1'b1; bus.exIsLoad = 1'b1; bus.exRd = 5'd5;
    endtask

    vec_t vecs[11];

    initial begin
        //          name              dV rs1    rs2    u1 u2 eV eL rd     br mb  expected
        vecs[0]  = '{"ld_x5_add_rs1",  1, 5'd5,  5'd2,  1, 1, 1, 1, 5'd5,  0, 0, 6'b111000};
        vecs[1]  = '{"load_left_ex",   1, 5'd5,  5'd2,  1, 1, 1, 0, 5'd5,  0, 0, 6'b000000};
        vecs[2]  = '{"ld_x0_no_stall", 1, 5'd0,  5'd2,  1, 1, 1, 1, 5'd0,  0, 0, 6'b000000};
        vecs[3]  = '{"ld_x7_store",    1, 5'd3,  5'd7,  0, 1, 1, 1, 5'd7,  0, 0, 6'b111000};
        vecs[4]  = '{"rs1_imm_match",  1, 5'd7,  5'd3,  0, 1, 1, 1, 5'd7,  0, 0, 6'b000000};
        vecs[5]  = '{"dec_invalid",    0, 5'd9,  5'd1,  1, 1, 1, 1, 5'd9,  0, 0, 6'b000000};
        vecs[6]  = '{"ex_invalid",     1, 5'd9,  5'd1,  1, 1, 0, 1, 5'd9,  0, 0, 6'b000000};
        vecs[7]  = '{"membusy_plain",  0, 5'd0,  5'd0,  0, 0, 0, 0, 5'd0,  0, 1, 6'b110000};
        vecs[8]  = '{"membusy_ldu",    1, 5'd5,  5'd2,  1, 1, 1, 1, 5'd5,  0, 1, 6'b110000};
        vecs[9]  = '{"br_membusy",     0, 5'd0,  5'd0,  0, 0, 1, 0, 5'd0,  1, 1, 6'b110000};
        vecs[10] = '{"rs2_match",      1, 5'd4,  5'd12, 1, 1, 1, 1, 5'd12, 0, 0, 6'b111000};

        // Reset holds everything low even with hazard and memBusy inputs active
        setLoadUse();
        bus.memBusy = 1'b1;
        #2;
        check("reset_outs", 32'(outs()), 32'd0);
        check("reset_perf_stall", bus.perfStallCycles, 32'd0);
        check("reset_perf_flush", 32'(bus.perfFlushCount), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle();

        // RUN-state vector table (no vector here takes the state machine into FLUSH)
        foreach (vecs[i]) begin
            @(negedge clk);
            applyVec(vecs[i]);
            step(vecs[i].name, vecs[i].expOut);
        end

        // Taken-branch pulse: 3 flush cycles, ctrlState 0,1,1,0
        @(negedge clk); idle(); bus.exValid = 1'b1; bus.exBranchTaken = 1'b1;
        step("br_c0", 6'b001110);
        @(negedge clk); idle();
        step("br_c1", 6'b001111);
        @(negedge clk); setLoadUse(); bus.exBranchTaken = 1'b1;
        step("br_c2_ignores", 6'b001111);
        @(negedge clk); idle();
        step("br_done", 6'b000000);

        // Branch held under memBusy: freeze only, flush starts when memBusy falls
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); idle(); bus.exBranchTaken = 1'b1; bus.memBusy = 1'b1;
            step($sformatf("brwait_%0d", c), 6'b110000);
        end
        @(negedge clk); bus.memBusy = 1'b0;
        step("brwait_start", 6'b001110);
        @(negedge clk); idle();
        step("brwait_f1", 6'b001111);
        @(negedge clk);
        step("brwait_f2", 6'b001111);
        @(negedge clk);
        step("brwait_done", 6'b000000);

        // memBusy during 2nd flush cycle for 2 cycles stretches flush to 5 cycles
        @(negedge clk); bus.exBranchTaken = 1'b1;
        step("ext_c0", 6'b001110);
        @(negedge clk); idle(); bus.memBusy = 1'b1;
        step("ext_c1_busy", 6'b110111);
        @(negedge clk);
        step("ext_c2_busy", 6'b110111);
        @(negedge clk); bus.memBusy = 1'b0;
        step("ext_c3", 6'b001111);
        @(negedge clk);
        step("ext_c4", 6'b001111);
        @(negedge clk);
        step("ext_done", 6'b000000);

        // Asynchronous reset in the middle of a flush
        @(negedge clk); bus.exBranchTaken = 1'b1;
        step("rstf_c0", 6'b001110);
        @(negedge clk); idle();
        step("rstf_c1", 6'b001111);
        #2 rst = 1'b1;
        step("rstf_async", 6'b000000);
        @(negedge clk); rst = 1'b0;
        step("rstf_after", 6'b000000);
        check("rstf_perf_stall", bus.perfStallCycles, 32'd0);
        check("rstf_perf_flush", 32'(bus.perfFlushCount), 32'd0);

        // After reset: one flush, two load-use stalls and one memory-wait stall
        @(negedge clk); bus.exBranchTaken = 1'b1;
        step("cnt_br", 6'b001110);
        @(negedge clk); idle();
        @(negedge clk);
        @(negedge clk);
        step("cnt_run", 6'b000000);
        @(negedge clk); setLoadUse();
        step("cnt_ldu0", 6'b111000);
        @(negedge clk);
        step("cnt_ldu1", 6'b111000);
        @(negedge clk); idle(); bus.memBusy = 1'b1;
        step("cnt_busy", 6'b110000);
        @(negedge clk); idle();
        #1;
        check("perf_stall", bus.perfStallCycles, PERF_EN ? 32'd3 : 32'd0);
        check("perf_flush", 32'(bus.perfFlushCount), PERF_EN ? 32'd1 : 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
